// File: rtl/reg_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_arbiter_pkg
//  Purpose  : Shared FSM state encodings and rw encodings for the register
//             access arbiter and its round-robin winner select.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_access_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Same encoding as the register bank rw input
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/reg_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin winner select. Scans ptr+1, ptr+2, ...
//             modulo NREQ and returns the first requester found.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            found
);

  // First set request after the pointer, wrapping at NREQ
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_arbiter
//  Purpose  : Round-robin arbiter sharing a small register bank between NREQ
//             requesters. Sole writer of the bank; returns tagged read data.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter
  import reg_access_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2,
  parameter int ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         rw,
  input  logic [NREQ*ADDR_W-1:0]  addr,
  input  logic [NREQ*DATA_W-1:0]  wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic [ID_W-1:0]         rid,
  output logic                    busy,
  output logic [NREGS-1:0]        bank_we,
  output logic [DATA_W-1:0]       bank_wdata,
  input  logic [NREGS*DATA_W-1:0] bank_q
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  // Pointer doubles as the latched winner: ptr always equals the last grant
  logic [ID_W-1:0]   r_ptr;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;

  logic [ID_W-1:0]   w_winner;
  logic              w_found;
  logic              w_sel_rw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREGS-1:0]  w_we_nxt;
  logic [DATA_W-1:0] w_bwd_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_rvalid_nxt;
  logic [ID_W-1:0]   w_rid_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  // Mux the winning requester's rw/addr/wdata out of the flattened buses
  always_comb begin
    w_sel_rw    = RW_READ;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(w_winner) == i) begin
        w_sel_rw    = rw[i];
        w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register plus the request latch captured when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= ID_W'(NREQ - 1);
      r_rw    <= RW_READ;
      r_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_found) begin
        r_ptr  <= w_winner;
        r_rw   <= w_sel_rw;
        r_addr <= w_sel_addr;
      end
    end
  end

  // Next-state decode: writes take IDLE->ACCESS, reads add a RESP cycle
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next_state = w_found ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next_state = (r_rw == RW_READ) ? ST_RESP : ST_IDLE;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: values the registered outputs take on the next edge
  always_comb begin
    w_gnt_nxt    = '0;
    w_we_nxt     = '0;
    w_bwd_nxt    = bank_wdata;
    w_rdata_nxt  = rdata;
    w_rvalid_nxt = 1'b0;
    w_rid_nxt    = rid;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          for (int i = 0; i < NREQ; i++)
            w_gnt_nxt[i] = (int'(w_winner) == i);
          // Out-of-range addresses match no register, so the write drops
          for (int r = 0; r < NREGS; r++)
            w_we_nxt[r] = (w_sel_rw == RW_WRITE) && (int'(w_sel_addr) == r);
          if (w_sel_rw == RW_WRITE)
            w_bwd_nxt = w_sel_wdata;
        end
      end
      ST_ACCESS: begin
        if (r_rw == RW_READ) begin
          w_rvalid_nxt = 1'b1;
          w_rid_nxt    = r_ptr;
          w_rdata_nxt  = '0;
          for (int r = 0; r < NREGS; r++)
            if (int'(r_addr) == r)
              w_rdata_nxt = bank_q[r*DATA_W +: DATA_W];
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      bank_we    <= '0;
      bank_wdata <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      rid        <= '0;
    end else begin
      gnt        <= w_gnt_nxt;
      bank_we    <= w_we_nxt;
      bank_wdata <= w_bwd_nxt;
      rdata      <= w_rdata_nxt;
      rvalid     <= w_rvalid_nxt;
      rid        <= w_rid_nxt;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_access_arbiter
//  Purpose  : Directed self-checking bench for reg_access_arbiter: default
//             configuration, a 3-requester instance and a 3-register instance,
//             each with a behavioural register bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Default instance: NREQ=2, NREGS=4
  logic [1:0]  req = '0, rw = '0, gnt;
  logic [3:0]  addr = '0, rdata, bank_we, bank_wdata;
  logic [7:0]  wdata = '0;
  logic        rvalid, busy;
  logic [0:0]  rid;
  logic [15:0] bank_q;

  // Three-requester instance
  logic [2:0]  req3 = '0, rw3 = '0, gnt3;
  logic [5:0]  addr3 = '0;
  logic [11:0] wdata3 = '0;
  logic [3:0]  rdata3, we3, bwd3;
  logic        rvalid3, busy3;
  logic [1:0]  rid3;
  logic [15:0] bq3;

  // Three-register instance
  logic [1:0]  reqn = '0, rwn = '0, gntn;
  logic [3:0]  addrn = '0, rdatan, bwdn;
  logic [7:0]  wdatan = '0;
  logic [2:0]  wen;
  logic        rvalidn, busyn;
  logic [0:0]  ridn;
  logic [11:0] bqn;

  reg_access_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy),
    .bank_we(bank_we), .bank_wdata(bank_wdata), .bank_q(bank_q));

  reg_access_arbiter #(.NREQ(3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .rw(rw3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .rdata(rdata3), .rvalid(rvalid3), .rid(rid3), .busy(busy3),
    .bank_we(we3), .bank_wdata(bwd3), .bank_q(bq3));

  reg_access_arbiter #(.NREGS(3)) dutn (
    .clk(clk), .rst(rst), .req(reqn), .rw(rwn), .addr(addrn), .wdata(wdatan),
    .gnt(gntn), .rdata(rdatan), .rvalid(rvalidn), .rid(ridn), .busy(busyn),
    .bank_we(wen), .bank_wdata(bwdn), .bank_q(bqn));

  // Behavioural register banks
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      bq3    <= '0;
      bqn    <= '0;
    end else begin
      for (int r = 0; r < 4; r++) if (bank_we[r]) bank_q[r*4 +: 4] <= bank_wdata;
      for (int r = 0; r < 4; r++) if (we3[r])     bq3[r*4 +: 4]    <= bwd3;
      for (int r = 0; r < 3; r++) if (wen[r])     bqn[r*4 +: 4]    <= bwdn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we", 32'(bank_we), 32'h0);
    chk("rst_wdata", 32'(bank_wdata), 32'h0);
    rst = 1'b0;

    // Test 1: requester 0 writes 4'hA to register 2
    req = 2'b01; rw = 2'b01; addr = 4'b0010; wdata = 8'h0A;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_we", 32'(bank_we), 32'h4);
    chk("t1_wdata", 32'(bank_wdata), 32'hA);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 2'b00;
    @(negedge clk);
    chk("t1_gnt_off", 32'(gnt), 32'h0);
    chk("t1_we_off", 32'(bank_we), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_bank2", 32'(bank_q[11:8]), 32'hA);
    chk("t1_wdata_hold", 32'(bank_wdata), 32'hA);

    // Test 2: requester 1 reads register 2
    req = 2'b10; rw = 2'b00; addr = 4'b1000;
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h2);
    chk("t2_we", 32'(bank_we), 32'h0);
    chk("t2_rvalid_early", 32'(rvalid), 32'h0);
    req = 2'b00;
    @(negedge clk);
    chk("t2_rvalid", 32'(rvalid), 32'h1);
    chk("t2_rid", 32'(rid), 32'h1);
    chk("t2_rdata", 32'(rdata), 32'hA);
    chk("t2_gnt_off", 32'(gnt), 32'h0);
    chk("t2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t2_rvalid_off", 32'(rvalid), 32'h0);
    chk("t2_rdata_hold", 32'(rdata), 32'hA);
    chk("t2_busy_off", 32'(busy), 32'h0);

    // Test 3: continuous contention, both write; grants alternate 0,1,0,1
    req = 2'b11; rw = 2'b11; addr = 4'b0100; wdata = 8'h53;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      chk("t3_gnt", 32'(gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
      if (g == 3) req = 2'b00;
      @(negedge clk);
      chk("t3_gnt_gap", 32'(gnt), 32'h0);
    end
    chk("t3_bank0", 32'(bank_q[3:0]), 32'h3);
    chk("t3_bank1", 32'(bank_q[7:4]), 32'h5);

    // Read-after-write: requester 0 reads register 1
    req = 2'b01; rw = 2'b00; addr = 4'b0001;
    @(negedge clk);
    chk("raw_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    @(negedge clk);
    chk("raw_rvalid", 32'(rvalid), 32'h1);
    chk("raw_rid", 32'(rid), 32'h0);
    chk("raw_rdata", 32'(rdata), 32'h5);
    @(negedge clk);

    // Test 4: reset during the ACCESS cycle of a read by requester 0
    req = 2'b01; rw = 2'b00; addr = 4'b0010;
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    chk("t4_gnt_rst", 32'(gnt), 32'h0);
    chk("t4_rvalid_rst", 32'(rvalid), 32'h0);
    chk("t4_rdata_rst", 32'(rdata), 32'h0);
    chk("t4_rid_rst", 32'(rid), 32'h0);
    chk("t4_busy_rst", 32'(busy), 32'h0);
    chk("t4_we_rst", 32'(bank_we), 32'h0);
    rst = 1'b0; req = 2'b11; rw = 2'b11; addr = 4'b0100; wdata = 8'h53;
    @(negedge clk);
    chk("t4_gnt_after", 32'(gnt), 32'h1);
    chk("t4_we_after", 32'(bank_we), 32'h1);
    chk("t4_no_rvalid", 32'(rvalid), 32'h0);
    req = 2'b00;
    @(negedge clk);

    // Test 5: NREQ=3, ptr=2 after reset, req=101 -> 0 wins, then 2
    req3 = 3'b101; rw3 = 3'b111; addr3 = 6'b000000; wdata3 = 12'h707;
    @(negedge clk);
    chk("t5_gnt_wrap", 32'(gnt3), 32'h1);
    @(negedge clk);
    chk("t5_gap", 32'(gnt3), 32'h0);
    @(negedge clk);
    chk("t5_gnt_next", 32'(gnt3), 32'h4);
    req3 = 3'b000;
    @(negedge clk);
    chk("t5_idle", 32'(gnt3), 32'h0);
    chk("t5_bank0", 32'(bq3[3:0]), 32'h7);

    // Test 6: NREGS=3; valid write, then out-of-range write and read
    reqn = 2'b01; rwn = 2'b01; addrn = 4'b0000; wdatan = 8'h09;
    @(negedge clk);
    chk("t6_gnt_w0", 32'(gntn), 32'h1);
    chk("t6_we_w0", 32'(wen), 32'h1);
    reqn = 2'b00;
    @(negedge clk);
    chk("t6_bank_w0", 32'(bqn), 32'h009);
    reqn = 2'b01; rwn = 2'b01; addrn = 4'b0011; wdatan = 8'h05;
    @(negedge clk);
    chk("t6_gnt_oor", 32'(gntn), 32'h1);
    chk("t6_we_oor", 32'(wen), 32'h0);
    reqn = 2'b00;
    @(negedge clk);
    chk("t6_bank_oor", 32'(bqn), 32'h009);
    reqn = 2'b10; rwn = 2'b00; addrn = 4'b0000;
    @(negedge clk);
    chk("t6_gnt_r0", 32'(gntn), 32'h2);
    reqn = 2'b00;
    @(negedge clk);
    chk("t6_rvalid_r0", 32'(rvalidn), 32'h1);
    chk("t6_rdata_r0", 32'(rdatan), 32'h9);
    chk("t6_rid_r0", 32'(ridn), 32'h1);
    @(negedge clk);
    reqn = 2'b10; rwn = 2'b00; addrn = 4'b1100;
    @(negedge clk);
    chk("t6_gnt_roor", 32'(gntn), 32'h2);
    reqn = 2'b00;
    @(negedge clk);
    chk("t6_rvalid_roor", 32'(rvalidn), 32'h1);
    chk("t6_rdata_roor", 32'(rdatan), 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
